// File: rtl/fq_pkg.sv
// rtl/fq_pkg.sv - shared FSM encoding, constants and entry type for the fetch queue
package fq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_KILL = 2'd2
    } fq_state_t;

    localparam int          PC_STEP     = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - circular buffer with wrap-bit pointers, push/pop/flush and occupancy
module fq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // Flush beats both push and pop; a push into a full buffer is legal only alongside a pop.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush returns both pointers to the empty position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !do_pop));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC, imem request/credit control, redirect kill and output queue (option: FQ_BYPASS_EN)
module fetch_queue
    import fq_pkg::*;
#(
    parameter  int                DEPTH    = 4,
    parameter  int                ADDR_W   = 32,
    parameter  int                INSTR_W  = 32,
    parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC),
    localparam int                CW       = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
    output logic [CW-1:0]      fq_count
);

    fq_state_t                   state;
    fq_state_t                   state_nxt;
    logic [ADDR_W-1:0]           fetch_pc;
    logic [ADDR_W-1:0]           tag_pc;
    logic                        inflight;
    logic                        accept;
    logic                        kill;
    logic                        has_credit;
    logic [CW:0]                 used;
    logic                        bypass;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [ADDR_W+INSTR_W-1:0]   head;

    // Credit counts the queued entries plus the one response that may still land.
    assign used       = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
    assign has_credit = (used < (CW+1)'(DEPTH));
    assign imem_req   = (state == ST_RUN) & has_credit;
    assign imem_addr  = fetch_pc;
    assign accept     = imem_req & imem_gnt;
    assign kill       = (state == ST_KILL);

`ifdef FQ_BYPASS_EN
    assign bypass = fifo_empty & imem_rvalid & ~kill & ~redirect & out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~fifo_empty | bypass;
    assign out_pc    = bypass ? tag_pc     : head[ADDR_W+INSTR_W-1:INSTR_W];
    assign out_instr = bypass ? imem_rdata : head[INSTR_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BOOT;
        else        state <= state_nxt;
    end

    // Next state: a redirect with a response pending or being accepted needs a kill cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  if (redirect && (inflight || accept)) state_nxt = ST_KILL;
            ST_KILL: state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Fetch PC, response tag and in-flight flag; redirect overrides the sequential step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            if (redirect)    fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (accept) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            if (accept)      tag_pc   <= fetch_pc;
            inflight <= accept;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (imem_rvalid & ~kill & ~bypass),
        .pop   (out_ready),
        .flush (redirect),
        .wdata ({tag_pc, imem_rdata}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fq_count)
    );

    a_resp_credit: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && !kill && !redirect && fifo_full && !out_ready));

endmodule
